// File: rtl/io_hub_pkg.sv
// io_hub_pkg: address window, register word offsets and TMR_CTRL bit positions for mmio_io_hub.
package io_hub_pkg;
  localparam logic [21:0] IO_WIN = 22'h3FFFFF;
  localparam logic [2:0] OFF_SW_DATA   = 3'd0;
  localparam logic [2:0] OFF_SW_EDGE   = 3'd1;
  localparam logic [2:0] OFF_LED_DATA  = 3'd2;
  localparam logic [2:0] OFF_LED_BLINK = 3'd3;
  localparam logic [2:0] OFF_TMR_LOAD  = 3'd4;
  localparam logic [2:0] OFF_TMR_CTRL  = 3'd5;
  localparam logic [2:0] OFF_TMR_COUNT = 3'd6;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_DONE = 2;
  localparam int CTRL_IE   = 3;
  localparam int CTRL_EIE  = 4;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: synchronises raw switches and accepts a change after DB_CYCLES stable cycles.
module io_debounce #(
  parameter int W           = 24,
  parameter int DB_CYCLES   = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] rise_o
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] sw_sync, prev_q, stable_q, rise_q;
  logic [CW-1:0] cnt_q;
  logic hit;
  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign hit = sw_sync == prev_q && sw_sync != stable_q && cnt_q == CW'(DB_CYCLES - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
      prev_q   <= sw_sync;
      cnt_q    <= (sw_sync != prev_q || sw_sync == stable_q || hit) ? '0 : cnt_q + CW'(1);
      stable_q <= hit ? sw_sync : stable_q;
      rise_q   <= hit ? sw_sync & ~stable_q : '0;
    end
  end
  assign stable_o = stable_q;
  assign rise_o   = rise_q;
endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped switches, blinking LEDs and a countdown timer in the top 1 KiB window.
module mmio_io_hub
  import io_hub_pkg::*;
#(
  parameter int SW_W        = 24,
  parameter int LED_W       = 24,
  parameter int DB_CYCLES   = 50000,
  parameter int BLINK_DIV   = 5000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);
  localparam int PW = $clog2(BLINK_DIV);
  logic [SW_W-1:0] stable, rise, edge_q, edge_d;
  logic [LED_W-1:0] led_data_q, led_data_d, led_blink_q, led_blink_d, led_q, led_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic en_q, en_d, ar_q, ar_d, done_q, done_d, tie_q, tie_d, eie_q, eie_d;
  logic [PW-1:0] presc_q, presc_d;
  logic phase_q, phase_d;
  logic hit, wr, wr_ctrl, expire, wrap, unused;
  logic [2:0] idx;
  io_debounce #(.W(SW_W), .DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db (
    .clk_i(clock), .rst_i(reset), .sw_i(switch_in), .stable_o(stable), .rise_o(rise)
  );
  assign unused  = ^addr[1:0];
  assign idx     = addr[4:2];
  assign hit     = addr[31:10] == IO_WIN && addr[9:5] == 5'd0;
  assign wr      = hit && io_wr;
  assign wr_ctrl = wr && idx == OFF_TMR_CTRL;
  assign expire  = en_q && count_q == 32'd1;
  assign wrap    = presc_q == PW'(BLINK_DIV - 1);
  always_comb begin
    led_data_d  = (wr && idx == OFF_LED_DATA) ? wdata[LED_W-1:0] : led_data_q;
    led_blink_d = (wr && idx == OFF_LED_BLINK) ? wdata[LED_W-1:0] : led_blink_q;
    load_d      = (wr && idx == OFF_TMR_LOAD) ? wdata : load_q;
    // A load write overrides both the reload value and the normal decrement
    count_d     = (wr && idx == OFF_TMR_LOAD) ? wdata :
                  expire ? (ar_q ? load_q : '0) :
                  (en_q && count_q != '0) ? count_q - 32'd1 : count_q;
    en_d        = wr_ctrl ? wdata[CTRL_EN] : en_q;
    ar_d        = wr_ctrl ? wdata[CTRL_AR] : ar_q;
    tie_d       = wr_ctrl ? wdata[CTRL_IE] : tie_q;
    eie_d       = wr_ctrl ? wdata[CTRL_EIE] : eie_q;
    done_d      = expire || (done_q && !(wr_ctrl && wdata[CTRL_DONE]));
    edge_d      = rise | (edge_q & ~((wr && idx == OFF_SW_EDGE) ? wdata[SW_W-1:0] : '0));
    presc_d     = wrap ? '0 : presc_q + PW'(1);
    phase_d     = phase_q ^ wrap;
    led_d       = led_data_d & (~led_blink_d | {LED_W{phase_d}});
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      led_data_q  <= '0;
      led_blink_q <= '0;
      led_q       <= '0;
      load_q      <= '0;
      count_q     <= '0;
      {en_q, ar_q, done_q, tie_q, eie_q} <= '0;
      edge_q      <= '0;
      presc_q     <= '0;
      phase_q     <= 1'b0;
    end else begin
      led_data_q  <= led_data_d;
      led_blink_q <= led_blink_d;
      led_q       <= led_d;
      load_q      <= load_d;
      count_q     <= count_d;
      {en_q, ar_q, done_q, tie_q, eie_q} <= {en_d, ar_d, done_d, tie_d, eie_d};
      edge_q      <= edge_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
    end
  end
  always_comb begin
    rdata = !(hit && io_rd)           ? '0 :
            idx == OFF_SW_DATA   ? 32'(stable) :
            idx == OFF_SW_EDGE   ? 32'(edge_q) :
            idx == OFF_LED_DATA  ? 32'(led_data_q) :
            idx == OFF_LED_BLINK ? 32'(led_blink_q) :
            idx == OFF_TMR_LOAD  ? load_q :
            idx == OFF_TMR_CTRL  ? 32'({eie_q, tie_q, done_q, ar_q, en_q}) :
            idx == OFF_TMR_COUNT ? count_q : '0;
  end
  assign led_out = led_q;
  assign irq     = (done_q && tie_q) || (|edge_q && eie_q);
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: scoreboard-driven check of register map, debounce, blink, timer and window decode.
module tb_mmio_io_hub;
  localparam int SW_W = 24;
  localparam int LED_W = 24;
  localparam logic [31:0] A_SW = 32'hFFFFFC00, A_EDGE = 32'hFFFFFC04, A_LED = 32'hFFFFFC08,
    A_BLINK = 32'hFFFFFC0C, A_LOAD = 32'hFFFFFC10, A_CTRL = 32'hFFFFFC14, A_CNT = 32'hFFFFFC18;
  logic clock = 0, reset = 1, io_rd = 0, io_wr = 0, sb_rd = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [SW_W-1:0] switch_in = 0;
  logic [LED_W-1:0] led_out, v, other, prev;
  logic irq;
  int vecs = 0, errs = 0, first = 0;
  logic found;
  logic [31:0] exp_q[$];
  string tag_q[$];
  always #5 clock = ~clock;
  mmio_io_hub #(.SW_W(SW_W), .LED_W(LED_W), .DB_CYCLES(4), .BLINK_DIV(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch_in(switch_in), .led_out(led_out), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (sb_rd) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  end
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    addr = a; io_rd = 1; sb_rd = 1;
    exp_q.push_back(e); tag_q.push_back(tag);
    @(posedge clock); #1;
    io_rd = 0; sb_rd = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; io_wr = 1;
    @(posedge clock); #1;
    io_wr = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle(3);
    reset = 0;
    chk("rst_led_out", 32'(led_out), 0);
    chk("rst_irq", 32'(irq), 0);
    rd(A_LED, 0, "rst_led_data");
    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_CNT, 0, "rst_count");
    // debounce latency and sticky edge
    switch_in = 24'h5; addr = A_SW; io_rd = 1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock); #1;
      if (first == 0 && rdata == 32'h5) first = i;
    end
    io_rd = 0;
    chk("db_latency_in_range", 32'(first >= 5 && first <= 7), 1);
    rd(A_SW, 32'h5, "sw_data");
    rd(A_EDGE, 32'h5, "sw_edge");
    switch_in = 24'h15; idle(2); switch_in = 24'h5; idle(12);
    rd(A_SW, 32'h5, "glitch_data");
    rd(A_EDGE, 32'h5, "glitch_edge");
    wr(A_EDGE, 32'h1);
    rd(A_EDGE, 32'h4, "edge_w1c");
    // LEDs and blink
    wr(A_LED, 32'hFF00);
    chk("led_next_cycle", 32'(led_out), 32'hFF00);
    addr = A_LED; #1;
    chk("rdata_no_rd", rdata, 0);
    wr(A_BLINK, 32'hF000);
    rd(A_LED, 32'hFF00, "led_data");
    rd(A_BLINK, 32'hF000, "led_blink");
    prev = led_out; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle(1);
      if (led_out != prev) found = 1;
    end
    chk("blink_toggle", 32'(found), 1);
    v = led_out;
    chk("blink_value", 32'(v == 24'hFF00 || v == 24'h0F00), 1);
    other = (v == 24'hFF00) ? 24'h0F00 : 24'hFF00;
    for (int j = 1; j < 8; j++) begin
      idle(1);
      chk("blink_seq", 32'(led_out), 32'(j < 4 ? v : other));
    end
    // auto-reload timer
    wr(A_LOAD, 3);
    rd(A_CNT, 3, "load_count");
    wr(A_CTRL, 32'h0B);
    for (int j = 0; j < 7; j++) begin
      chk("tmr_irq", 32'(irq), 32'(j >= 3));
      rd(A_CNT, 32'(3 - j % 3), "tmr_count");
    end
    wr(A_CTRL, 32'h0F);
    chk("irq_cleared", 32'(irq), 0);
    rd(A_CTRL, 32'h0B, "done_cleared");
    idle(2);
    wr(A_CTRL, 32'h0F);
    chk("irq_set_wins", 32'(irq), 1);
    rd(A_CTRL, 32'h0F, "done_set_wins");
    // one-shot
    wr(A_CTRL, 32'h01);
    rd(A_CNT, 1, "oneshot_1");
    rd(A_CNT, 0, "oneshot_0");
    rd(A_CNT, 0, "oneshot_idle");
    rd(A_CTRL, 32'h05, "oneshot_done");
    chk("irq_masked", 32'(irq), 0);
    // load write during expiry
    wr(A_CTRL, 32'h05);
    wr(A_LOAD, 2);
    idle(1);
    wr(A_LOAD, 7);
    rd(A_CNT, 7, "load_wins");
    rd(A_CTRL, 32'h05, "load_expiry_done");
    // edge interrupt
    wr(A_CTRL, 32'h10);
    chk("edge_irq", 32'(irq), 1);
    wr(A_EDGE, 32'hFFFFFF);
    chk("edge_irq_clr", 32'(irq), 0);
    // window decode
    wr(32'h00000008, 32'h123);
    wr(32'hFFFFFC28, 32'hABC);
    rd(32'h00000008, 0, "outside_window");
    rd(32'hFFFFFC28, 0, "high_offset");
    rd(A_LED, 32'hFF00, "led_kept");
    // simultaneous read and write
    exp_q.push_back(32'hF000); tag_q.push_back("rdwr_old");
    addr = A_BLINK; wdata = 0; io_rd = 1; io_wr = 1; sb_rd = 1;
    @(posedge clock); #1;
    io_rd = 0; io_wr = 0; sb_rd = 0;
    rd(A_BLINK, 0, "rdwr_commit");
    // reset mid-count
    wr(A_LOAD, 5);
    wr(A_CTRL, 32'h0B);
    idle(1);
    reset = 1; idle(1); reset = 0;
    rd(A_CNT, 0, "rst_mid_count");
    rd(A_CTRL, 0, "rst_mid_ctrl");
    rd(A_EDGE, 0, "rst_mid_edge");
    chk("rst_mid_irq", 32'(irq), 0);
    chk("rst_mid_led", 32'(led_out), 0);
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
